// File: rtl/core_mem_sequencer_if.sv
// Single valid/ready memory bus shared by instruction fetch and load/store access.
// The master modport is the sequencer side; the slave modport is the memory side.
interface core_mem_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/core_mem_sequencer.sv
// Fetch / execute / data / commit sequencer sharing one memory port for an RV32I core.
// Optional memory watchdog compiled in with `define MEM_TIMEOUT_EN (wait limit = TIMEOUT).
module core_mem_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  pc,
    input  logic                         is_load,
    input  logic                         is_store,
    input  logic                         ill_instr,
    input  logic [31:0]                  alu_addr,
    input  logic [31:0]                  store_data,
    output logic [31:0]                  instr_o,
    output logic [31:0]                  load_data_o,
    output logic                         commit,
    output logic                         halted,
    output logic                         bus_err,
    core_mem_sequencer_if.master         mem
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_EXEC,
        ST_DATA,
        ST_COMMIT,
        ST_HALT
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_load_data;
    logic        r_commit;
    logic        r_halted;
    logic        w_fetch;
    logic        w_data;
    logic        w_done;

    // Bus outputs depend only on state and on inputs held stable until commit,
    // so the async reset of r_state drops mem_req immediately.
    assign w_fetch       = (r_state == ST_FETCH);
    assign w_data        = (r_state == ST_DATA);
    assign mem.mem_req   = w_fetch | w_data;
    assign mem.mem_we    = w_data & is_store;
    assign mem.mem_addr  = w_fetch ? pc : (w_data ? alu_addr : 32'h0);
    assign mem.mem_wdata = w_data ? store_data : 32'h0;
    assign w_done        = mem.mem_req & mem.mem_ready;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] W_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait;
    logic       r_bus_err;
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_instr     <= NOP_INSTR;
            r_load_data <= 32'h0;
            r_commit    <= 1'b0;
            r_halted    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait      <= 8'h0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                ST_RST: begin
                    r_state <= ST_FETCH;
`ifdef MEM_TIMEOUT_EN
                    r_wait  <= 8'h0;
`endif
                end
                ST_FETCH, ST_DATA: begin
                    if (w_done) begin
                        if (w_fetch) begin
                            r_instr <= mem.mem_rdata;
                            r_state <= ST_EXEC;
                        end else begin
                            if (is_load) begin
                                r_load_data <= mem.mem_rdata;
                            end
                            r_state  <= ST_COMMIT;
                            r_commit <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    // A ready arriving on the final wait cycle takes the branch above.
                    else if (r_wait == W_TIMEOUT_LAST) begin
                        r_state   <= ST_HALT;
                        r_halted  <= 1'b1;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
`endif
                end
                ST_EXEC: begin
                    if (ill_instr || (is_load && is_store)) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (is_load || is_store) begin
                        r_state <= ST_DATA;
`ifdef MEM_TIMEOUT_EN
                        r_wait  <= 8'h0;
`endif
                    end else begin
                        r_state  <= ST_COMMIT;
                        r_commit <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_FETCH;
`ifdef MEM_TIMEOUT_EN
                    r_wait  <= 8'h0;
`endif
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign instr_o     = r_instr;
    assign load_data_o = r_load_data;
    assign commit      = r_commit;
    assign halted      = r_halted;

endmodule
